// File: rtl/meas_pkg.sv
// Shared types and widths for the measurement sequencer.
// WIN_W is the settle/window counter width for the default WIN_BASE.
package meas_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        COUNT  = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int WIN_BASE_DFLT = 8;
    localparam int TRIM_W        = 6;

    function automatic int win_w(input int base);
        return base + 8;
    endfunction

    localparam int WIN_W = win_w(WIN_BASE_DFLT);

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level, followed by a registered rising-edge pulse.
// The one-cycle pulse appears three clk cycles after the input transition.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic rise_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= sync_q & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/meas_sequencer.sv
// Analog-core measurement sequencer: settle, count comparator edges over a gate window, report.
// Control outputs are registered; result_byte is a combinational mux of the registered count.
module meas_sequencer
    import meas_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 256,
    parameter int WIN_BASE   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        win_sel,
    input  logic [TRIM_W-1:0] trim_in,
    input  logic              byte_sel,
    input  logic              comp_in,
    output logic              ana_en,
    output logic [TRIM_W-1:0] trim_out,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [7:0]        result_byte
);

    localparam int CTR_W = win_w(WIN_BASE);
    localparam logic [CTR_W-1:0] SETTLE_LOAD = CTR_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_e              state_q;
    logic [CTR_W-1:0]    ctr_q;
    logic [2:0]          win_q;
    logic [TRIM_W-1:0]   trim_q;
    logic [CNT_W-1:0]    result_q;
    logic                ovf_q;
    logic                ana_en_q;
    logic                busy_q;
    logic                done_q;
    logic                start_rise;
    logic                comp_rise;
    logic [CTR_W-1:0]    win_load;

    sync_edge u_start_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (start),
        .rise_o  (start_rise)
    );

    sync_edge u_comp_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (comp_in),
        .rise_o  (comp_rise)
    );

    // Terminal count for the gate window: the counter runs from 2^(WIN_BASE+win) - 1 down to 0.
    always_comb begin
        win_load = (CTR_W'(1) << (CTR_W'(WIN_BASE) + CTR_W'(win_q))) - CTR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ctr_q    <= '0;
            win_q    <= '0;
            trim_q   <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            ana_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_rise) begin
                        state_q  <= SETTLE;
                        trim_q   <= trim_in;
                        win_q    <= win_sel;
                        ctr_q    <= SETTLE_LOAD;
                        result_q <= '0;
                        ovf_q    <= 1'b0;
                        ana_en_q <= 1'b1;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (ctr_q == '0) begin
                        state_q <= COUNT;
                        ctr_q   <= win_load;
                    end else begin
                        ctr_q <= ctr_q - CTR_W'(1);
                    end
                end
                COUNT: begin
                    // Saturate rather than wrap; a dropped edge is what flags overflow.
                    if (comp_rise) begin
                        if (result_q == CNT_MAX) begin
                            ovf_q <= 1'b1;
                        end else begin
                            result_q <= result_q + CNT_W'(1);
                        end
                    end
                    if (ctr_q == '0) begin
                        state_q  <= DONE;
                        ana_en_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        ctr_q <= ctr_q - CTR_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        result_byte = result_q[7:0];
        if (byte_sel) begin
            result_byte = 8'(result_q >> 8);
        end
    end

    assign ana_en   = ana_en_q;
    assign trim_out = trim_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_meas_sequencer.sv
// Bench for meas_sequencer: a 16-bit and a 9-bit instance share all stimulus and are checked
// every cycle against a timeline model, plus hand-computed literal expectations.
module tb_meas_sequencer;

    localparam int S     = 256;
    localparam int WB    = 8;
    localparam int NC    = 32768;
    localparam int MAX16 = 65535;
    localparam int MAX9  = 511;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       start    = 1'b0;
    logic       byte_sel = 1'b0;
    logic       comp_in  = 1'b0;
    logic [2:0] win_sel  = 3'd0;
    logic [5:0] trim_in  = 6'd0;

    logic       a_ana_en, a_busy, a_done, a_overflow;
    logic [5:0] a_trim_out;
    logic [7:0] a_result_byte;
    logic       b_ana_en, b_busy, b_done, b_overflow;
    logic [5:0] b_trim_out;
    logic [7:0] b_result_byte;

    int cyc      = 0;
    int n_chk    = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int comp_per = 0;
    int bs_mode  = 0;

    bit comp_hi [NC];
    bit lvl_s   [NC];
    bit lvl_c   [NC];

    // Model: a run is described by the interval it entered SETTLE and its window size.
    bit m_act   = 1'b0;
    int m_t     = 0;
    int m_win   = 0;
    int m_trim  = 0;
    int m_edges = 0;

    meas_sequencer #(.CNT_W(16), .SETTLE_CYC(S), .WIN_BASE(WB)) dut_a (
        .clk (clk), .rst (rst), .start (start), .win_sel (win_sel), .trim_in (trim_in),
        .byte_sel (byte_sel), .comp_in (comp_in), .ana_en (a_ana_en), .trim_out (a_trim_out),
        .busy (a_busy), .done (a_done), .overflow (a_overflow), .result_byte (a_result_byte)
    );

    meas_sequencer #(.CNT_W(9), .SETTLE_CYC(S), .WIN_BASE(WB)) dut_b (
        .clk (clk), .rst (rst), .start (start), .win_sel (win_sel), .trim_in (trim_in),
        .byte_sel (byte_sel), .comp_in (comp_in), .ana_en (b_ana_en), .trim_out (b_trim_out),
        .busy (b_busy), .done (b_done), .overflow (b_overflow), .result_byte (b_result_byte)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        comp_in = 1'b0;
        if (comp_per != 0) begin
            if ((cyc % comp_per) < (comp_per / 2)) comp_in = 1'b1;
        end
        if (cyc < NC) begin
            if (comp_hi[cyc]) comp_in = 1'b1;
        end
        byte_sel = (bs_mode == 2) ? cyc[0] : (bs_mode == 1);
    end

    function automatic int phase(input int c);
        int d;
        int w;
        if (!m_act) return 0;
        d = c - m_t;
        w = 1 << (WB + m_win);
        if (d < S) return 1;
        if (d < S + w) return 2;
        return 3;
    endfunction

    function automatic int sat(input int e, input int mx);
        return (e > mx) ? mx : e;
    endfunction

    function automatic int sel_byte(input int r, input logic bs);
        return bs ? ((r >> 8) & 255) : (r & 255);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) begin
            n_pass++;
        end else begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : cmp
        int c;
        int ph;
        int ra;
        int rb;
        bit sp;
        bit cp;
        c = cyc;
        if (c < NC) begin
            lvl_s[c] = start;
            lvl_c[c] = comp_in;
        end
        ph = phase(c);
        ra = sat(m_edges, MAX16);
        rb = sat(m_edges, MAX9);
        if (c >= 1) begin
            chk("a_busy",     int'(a_busy),        int'(ph == 1 || ph == 2));
            chk("a_ana_en",   int'(a_ana_en),      int'(ph == 1 || ph == 2));
            chk("a_done",     int'(a_done),        int'(ph == 3));
            chk("a_trim_out", int'(a_trim_out),    m_trim);
            chk("a_overflow", int'(a_overflow),    int'(m_edges > MAX16));
            chk("a_result",   int'(a_result_byte), sel_byte(ra, byte_sel));
            chk("b_busy",     int'(b_busy),        int'(ph == 1 || ph == 2));
            chk("b_done",     int'(b_done),        int'(ph == 3));
            chk("b_trim_out", int'(b_trim_out),    m_trim);
            chk("b_overflow", int'(b_overflow),    int'(m_edges > MAX9));
            chk("b_result",   int'(b_result_byte), sel_byte(rb, byte_sel));
        end
        // An input rise driven in interval j is seen as a pulse in interval j+3.
        sp = (c >= 4 && c < NC) && lvl_s[c-3] && !lvl_s[c-4];
        cp = (c >= 4 && c < NC) && lvl_c[c-3] && !lvl_c[c-4];
        if (ph == 2 && cp) m_edges++;
        if (sp && (ph == 0 || ph == 3)) begin
            m_act   = 1'b1;
            m_t     = c + 1;
            m_win   = int'(win_sel);
            m_trim  = int'(trim_in);
            m_edges = 0;
        end
        if (rst) begin
            m_act   = 1'b0;
            m_edges = 0;
            m_trim  = 0;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(3);
        start = 1'b0;
        step(3);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (a_done !== 1'b1 && n < budget) begin
            step(1);
            n++;
        end
        chk("done_within_budget", int'(a_done === 1'b1), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int k;
        int busy_n;

        rst = 1'b1;
        step(4);
        chk("rst_busy",   int'(a_busy),        0);
        chk("rst_ana_en", int'(a_ana_en),      0);
        chk("rst_done",   int'(a_done),        0);
        chk("rst_trim",   int'(a_trim_out),    0);
        chk("rst_result", int'(a_result_byte), 0);
        rst = 1'b0;
        step(5);

        // Basic run: clk/8 comparator over a 256-cycle window.
        trim_in  = 6'h2A;
        win_sel  = 3'd0;
        comp_per = 8;
        bs_mode  = 2;
        pulse_start();
        chk("basic_trim", int'(a_trim_out), 8'h2A);
        wait_done(600);
        bs_mode = 0;
        step(1);
        chk("basic_lo_a", int'(a_result_byte), 32);
        chk("basic_lo_b", int'(b_result_byte), 32);
        bs_mode = 1;
        step(1);
        chk("basic_hi_a", int'(a_result_byte), 0);

        // Edges on the first and last COUNT cycles are counted.
        comp_per = 0;
        bs_mode  = 0;
        trim_in  = 6'h15;
        step(10);
        k = cyc;
        comp_hi[k + 257] = 1'b1;
        comp_hi[k + 512] = 1'b1;
        pulse_start();
        wait_done(600);
        step(6);
        chk("bound_inside", int'(a_result_byte), 2);

        // Edges one cycle before and one cycle after COUNT are not.
        step(10);
        k = cyc;
        comp_hi[k + 256] = 1'b1;
        comp_hi[k + 513] = 1'b1;
        pulse_start();
        wait_done(600);
        step(6);
        chk("bound_outside", int'(a_result_byte), 0);

        // Saturation: 512 edges over 1024 cycles.
        win_sel  = 3'd2;
        comp_per = 2;
        pulse_start();
        wait_done(1500);
        bs_mode = 1;
        step(1);
        chk("sat_hi_b",  int'(b_result_byte), 8'h01);
        chk("sat_hi_a",  int'(a_result_byte), 8'h02);
        chk("sat_ovf_b", int'(b_overflow),    1);
        chk("sat_ovf_a", int'(a_overflow),    0);
        bs_mode = 0;
        step(1);
        chk("sat_lo_b",  int'(b_result_byte), 8'hFF);
        chk("sat_lo_a",  int'(a_result_byte), 8'h00);

        // Window select 3 with a clk/4 comparator.
        win_sel  = 3'd3;
        comp_per = 4;
        bs_mode  = 2;
        busy_n   = 0;
        start    = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            step(1);
            if (n == 2) start = 1'b0;
            if (a_busy === 1'b1) busy_n++;
            if (a_done === 1'b1 && n > 8) break;
        end
        chk("win3_done",       int'(a_done), 1);
        chk("win3_busy_cycles", busy_n,      S + 2048);
        bs_mode = 1;
        step(1);
        chk("win3_hi_a",  int'(a_result_byte), 8'h02);
        chk("win3_hi_b",  int'(b_result_byte), 8'h01);
        chk("win3_ovf_a", int'(a_overflow),    0);

        // Start edges while busy are ignored; a held start level does not retrigger.
        win_sel  = 3'd0;
        comp_per = 8;
        bs_mode  = 0;
        trim_in  = 6'h33;
        step(5);
        start = 1'b1;
        step(3);
        start = 1'b0;
        step(97);
        start = 1'b1;
        step(4);
        start = 1'b0;
        step(200);
        start = 1'b1;
        step(4);
        start = 1'b0;
        step(50);
        start = 1'b1;
        wait_done(600);
        step(1);
        chk("retrig_count", int'(a_result_byte), 32);
        chk("retrig_trim",  int'(a_trim_out),    8'h33);
        step(300);
        chk("held_done", int'(a_done), 1);
        chk("held_busy", int'(a_busy), 0);
        start = 1'b0;
        step(5);
        start = 1'b1;
        step(6);
        chk("rerun_busy",   int'(a_busy),        1);
        chk("rerun_done",   int'(a_done),        0);
        chk("rerun_result", int'(a_result_byte), 0);
        start = 1'b0;

        // Reset for two cycles in the middle of COUNT.
        step(400);
        chk("mid_count_busy", int'(a_busy), 1);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        chk("abort_ana_en", int'(a_ana_en),      0);
        chk("abort_busy",   int'(a_busy),        0);
        chk("abort_done",   int'(a_done),        0);
        chk("abort_result", int'(a_result_byte), 0);
        chk("abort_trim",   int'(a_trim_out),    0);
        step(30);
        chk("abort_frozen_result", int'(a_result_byte), 0);
        chk("abort_frozen_busy",   int'(a_busy),        0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
